usb_rx_seq: RTL and testbench

Receive-path sequencer for the USB full-speed receiver. Watches the raw line samples for SYNC, then brackets the packet for the NRZI decoder with one-cycle start_rc_nrzi/end_rc_nrzi strobes. Also detects EOP, enforces a SYNC-hunt timeout and a maximum packet length, and reports packet status to the protocol layer.

---
 rtl/usb_rx_pkg.sv | 22 ++
 rtl/usb_rx_sync_det.sv | 32 +++
 rtl/usb_rx_seq.sv | 177 +++++++++++++++++
 tb/tb_usb_rx_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive sequencer.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        START,
        RECV,
        EOP,
        DRAIN
    } state_t;

    typedef enum logic {
        LINE_K = 1'b0,
        LINE_J = 1'b1
    } line_t;

    // KJKJKJKK with the oldest bit in bit 7
    localparam logic [7:0] SYNC_PATTERN = 8'b0101_0100;
    localparam logic [7:0] SYNC_IDLE    = 8'hFF;

endpackage

// File: rtl/usb_rx_sync_det.sv
// SYNC detector: 8-bit raw-bit history with a match flag that already
// reflects the bit arriving on the current strobe.
module usb_rx_sync_det
    import usb_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_stb,
    input  logic raw_bit,
    input  logic se0,
    input  logic clear,
    output logic match_c
);

    logic [7:0] sync_sr;
    logic [7:0] shifted;

    assign shifted = {sync_sr[6:0], raw_bit};
    assign match_c = bit_stb && !se0 && (shifted == SYNC_PATTERN);

    // SE0 breaks any partial SYNC, so it restarts the history like a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_sr <= SYNC_IDLE;
        end else if (clear || (bit_stb && se0)) begin
            sync_sr <= SYNC_IDLE;
        end else if (bit_stb) begin
            sync_sr <= shifted;
        end
    end

endmodule

// File: rtl/usb_rx_seq.sv
// USB full-speed receive sequencer: SYNC hunt, packet bracketing, EOP and
// overflow handling. Define USB_RX_SEQ_STATS_EN to build the error counter.
module usb_rx_seq
    import usb_rx_pkg::*;
#(
    parameter int unsigned TIMEOUT_BITS = 255,
    parameter int unsigned MAX_BITS     = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rx_enable,
    input  logic                           bit_stb,
    input  logic                           raw_bit,
    input  logic                           se0,
    output logic                           start_rc_nrzi,
    output logic                           end_rc_nrzi,
    output logic                           rx_busy,
    output logic [$clog2(MAX_BITS+1)-1:0]  bit_cnt,
    output logic                           pkt_done,
    output logic                           pkt_timeout,
    output logic                           pkt_err,
    output logic [7:0]                     err_cnt
);

    localparam int unsigned CW = $clog2(MAX_BITS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_BITS + 1);

    state_t          state, next_state;
    logic [TW-1:0]   hunt_tmr, hunt_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic            se0_seen, se0_nxt;
    logic            start_nxt, end_nxt, done_nxt, tmo_nxt, ovf_nxt, busy_nxt;
    logic            sync_clr;
    logic            sync_match;

    usb_rx_sync_det u_sync_det (
        .clk     (clk),
        .rst     (rst),
        .bit_stb (bit_stb),
        .raw_bit (raw_bit),
        .se0     (se0),
        .clear   (sync_clr),
        .match_c (sync_match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            hunt_tmr      <= '0;
            bit_cnt       <= '0;
            se0_seen      <= 1'b0;
            start_rc_nrzi <= 1'b0;
            end_rc_nrzi   <= 1'b0;
            pkt_done      <= 1'b0;
            pkt_timeout   <= 1'b0;
            pkt_err       <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            state         <= next_state;
            hunt_tmr      <= hunt_nxt;
            bit_cnt       <= cnt_nxt;
            se0_seen      <= se0_nxt;
            start_rc_nrzi <= start_nxt;
            end_rc_nrzi   <= end_nxt;
            pkt_done      <= done_nxt;
            pkt_timeout   <= tmo_nxt;
            pkt_err       <= ovf_nxt;
            rx_busy       <= busy_nxt;
        end
    end

    // Pulses are computed on the transition so they appear in the cycle
    // the FSM occupies the corresponding state.
    always_comb begin
        next_state = state;
        hunt_nxt   = hunt_tmr;
        cnt_nxt    = bit_cnt;
        se0_nxt    = se0_seen;
        start_nxt  = 1'b0;
        end_nxt    = 1'b0;
        done_nxt   = 1'b0;
        tmo_nxt    = 1'b0;
        ovf_nxt    = 1'b0;
        sync_clr   = 1'b0;

        case (state)
            IDLE: begin
                if (rx_enable) begin
                    next_state = HUNT;
                    hunt_nxt   = '0;
                    sync_clr   = 1'b1;
                end
            end
            HUNT: begin
                if (!rx_enable) begin
                    next_state = IDLE;
                end else if (bit_stb) begin
                    if (sync_match) begin
                        next_state = START;
                        start_nxt  = 1'b1;
                        cnt_nxt    = '0;
                        se0_nxt    = 1'b0;
                    end else begin
                        hunt_nxt = hunt_tmr + TW'(1);
                        if (hunt_tmr == TW'(TIMEOUT_BITS - 1)) begin
                            next_state = IDLE;
                            tmo_nxt    = 1'b1;
                        end
                    end
                end
            end
            START: begin
                next_state = RECV;
            end
            RECV: begin
                if (bit_stb) begin
                    if (se0) begin
                        if (se0_seen) begin
                            next_state = EOP;
                            end_nxt    = 1'b1;
                            done_nxt   = 1'b1;
                        end else begin
                            se0_nxt = 1'b1;
                        end
                    end else begin
                        se0_nxt = 1'b0;
                        if (bit_cnt != CW'(MAX_BITS)) begin
                            cnt_nxt = bit_cnt + CW'(1);
                        end
                        if (bit_cnt == CW'(MAX_BITS - 1)) begin
                            next_state = DRAIN;
                            end_nxt    = 1'b1;
                            ovf_nxt    = 1'b1;
                        end
                    end
                end
            end
            EOP: begin
                next_state = IDLE;
            end
            DRAIN: begin
                // Swallow the rest of the oversized packet up to its EOP
                if (bit_stb) begin
                    if (se0) begin
                        if (se0_seen) begin
                            next_state = IDLE;
                        end else begin
                            se0_nxt = 1'b1;
                        end
                    end else begin
                        se0_nxt = 1'b0;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        busy_nxt = (next_state == START) || (next_state == RECV) ||
                   (next_state == DRAIN);
    end

`ifdef USB_RX_SEQ_STATS_EN
    // Saturating count of timeout and overflow events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if ((pkt_timeout || pkt_err) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_usb_rx_seq.sv
// Directed bench for usb_rx_seq (MAX_BITS=32); exercises error counting too
// when built with USB_RX_SEQ_STATS_EN.
module tb_usb_rx_seq;
    import usb_rx_pkg::*;

    localparam int unsigned MAXB = 32;
    localparam int unsigned TMO  = 255;
`ifdef USB_RX_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        int ndata;
        int se0_at;
        bit exp_done;
        bit exp_err;
        int exp_cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_enable;
    logic       bit_stb;
    logic       raw_bit;
    logic       se0;
    logic       start_rc_nrzi;
    logic       end_rc_nrzi;
    logic       rx_busy;
    logic [5:0] bit_cnt;
    logic       pkt_done;
    logic       pkt_timeout;
    logic       pkt_err;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;
    int exp_errs = 0;
    int n_start = 0;
    int n_end = 0;
    int n_done = 0;
    int n_tmo = 0;
    int n_err = 0;
    logic [7:0] sync_bits;
    vec_t tbl [6];

    usb_rx_seq #(
        .TIMEOUT_BITS (TMO),
        .MAX_BITS     (MAXB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_enable     (rx_enable),
        .bit_stb       (bit_stb),
        .raw_bit       (raw_bit),
        .se0           (se0),
        .start_rc_nrzi (start_rc_nrzi),
        .end_rc_nrzi   (end_rc_nrzi),
        .rx_busy       (rx_busy),
        .bit_cnt       (bit_cnt),
        .pkt_done      (pkt_done),
        .pkt_timeout   (pkt_timeout),
        .pkt_err       (pkt_err),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_rc_nrzi) n_start++;
        if (end_rc_nrzi)   n_end++;
        if (pkt_done)      n_done++;
        if (pkt_timeout)   n_tmo++;
        if (pkt_err)       n_err++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_ec();
        if (!STATS) return 32'd0;
        return (exp_errs > 255) ? 32'd255 : 32'(exp_errs);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One strobe cycle then one quiet cycle; returns where the strobe's
    // registered result is visible.
    task automatic send_bit(input logic r, input logic s);
        @(negedge clk);
        bit_stb = 1'b1;
        raw_bit = r;
        se0     = s;
        @(negedge clk);
        bit_stb = 1'b0;
        raw_bit = 1'b1;
        se0     = 1'b0;
    endtask

    task automatic send_sync();
        for (int i = 0; i < 8; i++) begin
            send_bit(sync_bits[7-i], 1'b0);
            if (i == 6) chk("no_early_start", 32'(start_rc_nrzi), 32'd0);
        end
        chk("start_after_sync", 32'(start_rc_nrzi), 32'd1);
        chk("busy_in_start", 32'(rx_busy), 32'd1);
        chk("cnt_zero_at_start", 32'(bit_cnt), 32'd0);
    endtask

    task automatic run_pkt(input vec_t v);
        int s0, e0, d0, r0;
        logic b;
        s0 = n_start; e0 = n_end; d0 = n_done; r0 = n_err;
        rx_enable = 1'b1;
        idle(2);
        send_sync();
        for (int i = 0; i < v.ndata; i++) begin
            if (i == v.se0_at) send_bit(1'b0, 1'b1);
            b = 1'($urandom_range(0, 1));
            send_bit(b, 1'b0);
            if (i == int'(MAXB) - 1) begin
                chk("ovf_end", 32'(end_rc_nrzi), 32'd1);
                chk("ovf_err", 32'(pkt_err), 32'd1);
                chk("ovf_no_done", 32'(pkt_done), 32'd0);
            end
        end
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        chk("eop_end", 32'(end_rc_nrzi), 32'(v.exp_done));
        chk("eop_done", 32'(pkt_done), 32'(v.exp_done));
        idle(1);
        chk("idle_after_pkt", 32'(rx_busy), 32'd0);
        chk("bit_cnt", 32'(bit_cnt), 32'(v.exp_cnt));
        rx_enable = 1'b0;
        idle(2);
        chk("start_count", 32'(n_start - s0), 32'd1);
        chk("end_count", 32'(n_end - e0), 32'd1);
        chk("done_count", 32'(n_done - d0), 32'(v.exp_done));
        chk("err_count", 32'(n_err - r0), 32'(v.exp_err));
        if (v.exp_err) exp_errs++;
        chk("err_cnt", 32'(err_cnt), exp_ec());
    endtask

    task automatic run_timeout(input bit detail);
        int s0, t0;
        s0 = n_start; t0 = n_tmo;
        rx_enable = 1'b0;
        idle(2);
        rx_enable = 1'b1;
        idle(2);
        for (int i = 0; i < int'(TMO); i++) begin
            send_bit(LINE_J, 1'b0);
            if (detail && i == int'(TMO) - 2)
                chk("no_early_timeout", 32'(pkt_timeout), 32'd0);
        end
        chk("timeout_pulse", 32'(pkt_timeout), 32'd1);
        chk("timeout_no_start", 32'(n_start - s0), 32'd0);
        idle(1);
        chk("timeout_one_cycle", 32'(pkt_timeout), 32'd0);
        exp_errs++;
        if (detail) begin
            // Timeout returned to IDLE; rx_enable still high so a fresh hunt accepts SYNC
            send_sync();
            send_bit(LINE_K, 1'b0);
            send_bit(1'b0, 1'b1);
            send_bit(1'b0, 1'b1);
            chk("post_timeout_done", 32'(pkt_done), 32'd1);
            chk("timeout_count", 32'(n_tmo - t0), 32'd1);
        end
        rx_enable = 1'b0;
        idle(2);
        chk("err_cnt_tmo", 32'(err_cnt), exp_ec());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int e0;
        tbl[0] = '{16, -1, 1'b1, 1'b0, 16};
        tbl[1] = '{ 8,  5, 1'b1, 1'b0,  8};
        tbl[2] = '{ 0, -1, 1'b1, 1'b0,  0};
        tbl[3] = '{31, -1, 1'b1, 1'b0, 31};
        tbl[4] = '{32, -1, 1'b0, 1'b1, 32};
        tbl[5] = '{40, -1, 1'b0, 1'b1, 32};
        sync_bits = SYNC_PATTERN;

        rst = 1'b1; rx_enable = 1'b0; bit_stb = 1'b0; raw_bit = 1'b1; se0 = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(2);
        chk("rst_start", 32'(start_rc_nrzi), 32'd0);
        chk("rst_end", 32'(end_rc_nrzi), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        chk("rst_done", 32'(pkt_done), 32'd0);
        chk("rst_timeout", 32'(pkt_timeout), 32'd0);
        chk("rst_err", 32'(pkt_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);

        for (int k = 0; k < 6; k++) run_pkt(tbl[k]);

        // SYNC completing on the timeout strobe must start the packet
        rx_enable = 1'b1;
        idle(2);
        for (int i = 0; i < int'(TMO) - 8; i++) send_bit(LINE_J, 1'b0);
        send_sync();
        chk("sync_beats_timeout", 32'(pkt_timeout), 32'd0);
        send_bit(LINE_J, 1'b0);
        send_bit(LINE_K, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        chk("race_done", 32'(pkt_done), 32'd1);
        idle(1);
        chk("race_bit_cnt", 32'(bit_cnt), 32'd2);
        rx_enable = 1'b0;
        idle(2);

        run_timeout(1'b1);

        // Reset in the middle of a packet
        rx_enable = 1'b1;
        idle(2);
        send_sync();
        for (int i = 0; i < 10; i++) send_bit(LINE_K, 1'b0);
        chk("mid_bit_cnt", 32'(bit_cnt), 32'd10);
        e0 = n_end;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(rx_busy), 32'd0);
        chk("mid_rst_bit_cnt", 32'(bit_cnt), 32'd0);
        chk("mid_rst_end", 32'(end_rc_nrzi), 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        idle(2);
        rst = 1'b0;
        rx_enable = 1'b0;
        idle(2);
        chk("mid_rst_no_end", 32'(n_end - e0), 32'd0);
        exp_errs = 0;
        run_pkt(tbl[0]);

`ifdef USB_RX_SEQ_STATS_EN
        repeat (3) run_timeout(1'b0);
        run_pkt(tbl[4]);
        chk("err_cnt_four", 32'(err_cnt), 32'd4);
        for (int k = 0; k < 296; k++) run_pkt(tbl[4]);
        chk("err_cnt_saturated", 32'(err_cnt), 32'd255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
